ysyx_24110006_mdu: RTL and testbench

YSYX_24110006_MDU -- requirements
Module: ysyx_24110006_MDU

---
 rtl/ysyx_24110006_mdu.sv | 136 +++++++++++++
 tb/tb_ysyx_24110006_mdu.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24110006_mdu.sv
// rtl/ysyx_24110006_mdu.sv - RV M-extension multiply/divide unit
// Iterative shift-add / restoring-divide datapath on magnitudes, optional single-cycle multiply.
module ysyx_24110006_mdu #(
    parameter int XLEN     = 32,
    parameter bit FAST_MUL = 1'b0
) (
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [2:0]      i_func,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result,
    output logic            o_busy
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
    state_t state, state_n;

    logic [CW-1:0]   cnt;
    logic [2:0]      func_q;
    logic [XLEN-1:0] hi_q, lo_q, b_q;
    logic            neg_q, rneg_q;

    logic            a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf, take_fast;
    logic [XLEN-1:0] a_abs, b_abs, fast_result;
    logic [2*XLEN-1:0] fast_prod;

    always_comb begin
        a_signed  = (i_func == 3'b001) || (i_func == 3'b010) || (i_func == 3'b100) || (i_func == 3'b110);
        b_signed  = (i_func == 3'b001) || (i_func == 3'b100) || (i_func == 3'b110);
        a_neg     = a_signed & i_a[XLEN-1];
        b_neg     = b_signed & i_b[XLEN-1];
        a_abs     = a_neg ? -i_a : i_a;
        b_abs     = b_neg ? -i_b : i_b;
        div_zero  = i_func[2] & (i_b == '0);
        div_ovf   = i_func[2] & ~i_func[0] & (i_a == MIN_NEG) & (i_b == '1);
        take_fast = div_zero | div_ovf | (FAST_MUL & ~i_func[2]);
        fast_prod = '0;
        if (FAST_MUL) begin
            fast_prod = {{XLEN{1'b0}}, a_abs} * {{XLEN{1'b0}}, b_abs};
            if (a_neg ^ b_neg) fast_prod = -fast_prod;
        end
        if (div_zero)
            fast_result = i_func[1] ? i_a : '1;
        else if (div_ovf)
            fast_result = i_func[1] ? '0 : i_a;
        else
            fast_result = (i_func[1:0] == 2'b00) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    end

    // hi_q holds partial product / partial remainder; lo_q holds multiplier / quotient bits.
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [XLEN-1:0]   hi_n, lo_n, q_fix, r_fix, final_result;
    logic [2*XLEN-1:0] prod_fix;

    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, b_q};
        if (func_q[2]) begin
            if (!div_diff[XLEN]) begin
                hi_n = div_diff[XLEN-1:0];
                lo_n = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                hi_n = div_shift[XLEN-1:0];
                lo_n = {lo_q[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_n = mul_sum[XLEN:1];
            lo_n = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        prod_fix = neg_q ? -{hi_n, lo_n} : {hi_n, lo_n};
        q_fix    = neg_q ? -lo_n : lo_n;
        r_fix    = rneg_q ? -hi_n : hi_n;
        if (func_q[2])
            final_result = func_q[1] ? r_fix : q_fix;
        else
            final_result = (func_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) state <= S_IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (i_valid) state_n = take_fast ? S_DONE : S_BUSY;
            S_BUSY:  if (cnt == '0) state_n = S_DONE;
            S_DONE:  if (i_ready) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        if (i_flush) state_n = S_IDLE;
    end

    assign o_ready = (state == S_IDLE);
    assign o_valid = (state == S_DONE);
    assign o_busy  = (state == S_BUSY);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            cnt      <= '0;
            o_result <= '0;
            func_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
        end else if (!i_flush) begin
            if (state == S_IDLE && i_valid) begin
                func_q <= i_func;
                hi_q   <= '0;
                lo_q   <= a_abs;
                b_q    <= b_abs;
                neg_q  <= a_neg ^ b_neg;
                rneg_q <= a_neg;
                if (take_fast) o_result <= fast_result;
                else           cnt      <= CW'(XLEN - 1);
            end else if (state == S_BUSY) begin
                hi_q <= hi_n;
                lo_q <= lo_n;
                cnt  <= cnt - CW'(1);
                if (cnt == '0) o_result <= final_result;
            end
        end
    end
endmodule

// File: tb/tb_ysyx_24110006_mdu.sv
// tb/tb_ysyx_24110006_mdu.sv - self-checking bench for ysyx_24110006_mdu
module tb_ysyx_24110006_mdu;
    logic        i_clock = 1'b0;
    logic        i_reset, i_flush, i_valid0, i_valid1, i_ready0, i_ready1;
    logic [2:0]  i_func;
    logic [31:0] i_a, i_b;
    logic        o_ready0, o_valid0, o_busy0, o_ready1, o_valid1, o_busy1;
    logic [31:0] o_result0, o_result1;
    int checks = 0;
    int errors = 0;

    always #5 i_clock = ~i_clock;

    ysyx_24110006_mdu #(.XLEN(32), .FAST_MUL(1'b0)) dut0 (
        .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid0), .o_ready(o_ready0),
        .i_func(i_func), .i_a(i_a), .i_b(i_b), .i_flush(i_flush), .o_valid(o_valid0),
        .i_ready(i_ready0), .o_result(o_result0), .o_busy(o_busy0));

    ysyx_24110006_mdu #(.XLEN(32), .FAST_MUL(1'b1)) dut1 (
        .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid1), .o_ready(o_ready1),
        .i_func(i_func), .i_a(i_a), .i_b(i_b), .i_flush(i_flush), .o_valid(o_valid1),
        .i_ready(i_ready1), .o_result(o_result1), .o_busy(o_busy1));

    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'b0, a};
        ub = {32'b0, b};
        p  = '0;
        case (f)
            3'd0: begin p = ua * ub;          return p[31:0];  end
            3'd1: begin p = sa * sb;          return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub;          return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic int ref_latency(input bit fast, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 32'd0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
        if (!f[2] && fast) return 1;
        return 33;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 9))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic do_op(input bit which, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat);
        i_func = f; i_a = a; i_b = b;
        if (which) i_valid1 = 1'b1; else i_valid0 = 1'b1;
        @(posedge i_clock); #1;
        i_valid0 = 1'b0; i_valid1 = 1'b0;
        lat = 1;
        while (!(which ? o_valid1 : o_valid0) && lat < 200) begin
            @(posedge i_clock); #1;
            lat++;
        end
        res = which ? o_result1 : o_result0;
        if (which) i_ready1 = 1'b1; else i_ready0 = 1'b1;
        @(posedge i_clock); #1;
        i_ready0 = 1'b0; i_ready1 = 1'b0;
    endtask

    task automatic test_reset();
        i_reset = 1'b1; i_flush = 1'b0; i_valid0 = 1'b0; i_valid1 = 1'b0;
        i_ready0 = 1'b0; i_ready1 = 1'b0; i_func = '0; i_a = '0; i_b = '0;
        repeat (3) @(posedge i_clock);
        #1 i_reset = 1'b0;
        checks++;
        if ({o_ready0, o_valid0, o_busy0} !== 3'b100) begin
            errors++; $display("FAIL reset_flags got %b exp 100", {o_ready0, o_valid0, o_busy0});
        end
        checks++;
        if (o_result0 !== 32'd0) begin
            errors++; $display("FAIL reset_result got %h exp 00000000", o_result0);
        end
    endtask

    task automatic test_directed();
        logic [2:0]  f[11]   = '{0, 3, 1, 4, 6, 5, 7, 5, 6, 4, 6};
        logic [31:0] a[11]   = '{7, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFF9, 32'hFFFFFFF9, 100, 100, 5, 5,
                                 32'h80000000, 32'h80000000};
        logic [31:0] b[11]   = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 2, 2, 7, 7, 0, 0,
                                 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] exp[11] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'h40000000, 32'hFFFFFFFD, 32'hFFFFFFFF,
                                 14, 2, 32'hFFFFFFFF, 5, 32'h80000000, 0};
        int          el[11]  = '{33, 33, 33, 33, 33, 33, 33, 1, 1, 1, 1};
        logic [31:0] res;
        int          lat;
        for (int i = 0; i < 11; i++) begin
            do_op(1'b0, f[i], a[i], b[i], res, lat);
            checks++;
            if (res !== exp[i]) begin
                errors++; $display("FAIL directed_result[%0d] got %h exp %h", i, res, exp[i]);
            end
            checks++;
            if (lat != el[i]) begin
                errors++; $display("FAIL directed_latency[%0d] got %0d exp %0d", i, lat, el[i]);
            end
        end
    endtask

    task automatic test_random(input bit which, input int n);
        logic [2:0]  f;
        logic [31:0] a, b, res;
        int          lat;
        for (int i = 0; i < n; i++) begin
            f = 3'($urandom_range(0, 7));
            a = pick_operand();
            b = pick_operand();
            do_op(which, f, a, b, res, lat);
            checks++;
            if (res !== ref_result(f, a, b)) begin
                errors++;
                $display("FAIL random_result dut%0d f=%0d a=%h b=%h got %h exp %h", which, f, a, b, res, ref_result(f, a, b));
            end
            checks++;
            if (lat != ref_latency(which, f, a, b)) begin
                errors++;
                $display("FAIL random_latency dut%0d f=%0d got %0d exp %0d", which, f, lat, ref_latency(which, f, a, b));
            end
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        i_func = 3'd5; i_a = 100; i_b = 7; i_valid0 = 1'b1;
        @(posedge i_clock); #1;
        i_valid0 = 1'b0;
        while (!o_valid0 && n < 100) begin @(posedge i_clock); #1; n++; end
        for (int i = 0; i < 5; i++) begin
            @(posedge i_clock); #1;
            checks++;
            if ({o_valid0, o_ready0} !== 2'b10 || o_result0 !== 32'd14) begin
                errors++;
                $display("FAIL backpressure_hold[%0d] got valid=%b ready=%b res=%h exp valid=1 ready=0 res=0000000e",
                         i, o_valid0, o_ready0, o_result0);
            end
        end
        // release with a new request already waiting: it must not be taken on the release edge
        i_ready0 = 1'b1; i_valid0 = 1'b1; i_func = 3'd5; i_a = 5; i_b = 0;
        @(posedge i_clock); #1;
        i_ready0 = 1'b0;
        checks++;
        if ({o_ready0, o_valid0} !== 2'b10) begin
            errors++; $display("FAIL release_to_idle got ready=%b valid=%b exp ready=1 valid=0", o_ready0, o_valid0);
        end
        @(posedge i_clock); #1;
        i_valid0 = 1'b0;
        checks++;
        if (o_valid0 !== 1'b1 || o_result0 !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL accept_after_release got valid=%b res=%h exp valid=1 res=ffffffff", o_valid0, o_result0);
        end
        i_ready0 = 1'b1;
        @(posedge i_clock); #1;
        i_ready0 = 1'b0;
    endtask

    task automatic test_flush_reset();
        bit          seen;
        logic [31:0] res;
        int          lat;
        for (int pass = 0; pass < 2; pass++) begin
            i_func = 3'd0; i_a = 5; i_b = 6; i_valid0 = 1'b1;
            @(posedge i_clock); #1;
            i_valid0 = 1'b0;
            checks++;
            if (o_busy0 !== 1'b1) begin
                errors++; $display("FAIL busy_after_accept[%0d] got %b exp 1", pass, o_busy0);
            end
            repeat (9) @(posedge i_clock);
            #1;
            if (pass == 0) i_flush = 1'b1; else i_reset = 1'b1;
            @(posedge i_clock); #1;
            i_flush = 1'b0; i_reset = 1'b0;
            checks++;
            if ({o_ready0, o_busy0, o_valid0} !== 3'b100) begin
                errors++; $display("FAIL abort_idle[%0d] got %b exp 100", pass, {o_ready0, o_busy0, o_valid0});
            end
            seen = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(posedge i_clock); #1;
                seen |= o_valid0;
            end
            checks++;
            if (seen !== 1'b0) begin
                errors++; $display("FAIL abort_no_valid[%0d] got %b exp 0", pass, seen);
            end
        end
        checks++;
        if (o_result0 !== 32'd0) begin
            errors++; $display("FAIL reset_clears_result got %h exp 00000000", o_result0);
        end
        // flush wins over a same-cycle accept
        i_func = 3'd5; i_a = 9; i_b = 0; i_valid0 = 1'b1; i_flush = 1'b1;
        @(posedge i_clock); #1;
        i_valid0 = 1'b0; i_flush = 1'b0;
        checks++;
        if ({o_ready0, o_busy0, o_valid0} !== 3'b100) begin
            errors++; $display("FAIL flush_beats_accept got %b exp 100", {o_ready0, o_busy0, o_valid0});
        end
        do_op(1'b0, 3'd0, 3, 4, res, lat);
        checks++;
        if (res !== 32'd12 || lat != 33) begin
            errors++; $display("FAIL mul_after_abort got res=%h lat=%0d exp res=0000000c lat=33", res, lat);
        end
    endtask

    task automatic test_fast_mul();
        logic [31:0] res;
        int          lat;
        do_op(1'b1, 3'd0, 32'h1234_5678, 32'h10, res, lat);
        checks++;
        if (res !== 32'h2345_6780 || lat != 1) begin
            errors++; $display("FAIL fast_mul got res=%h lat=%0d exp res=23456780 lat=1", res, lat);
        end
        do_op(1'b1, 3'd4, 100, 7, res, lat);
        checks++;
        if (res !== 32'd14 || lat != 33) begin
            errors++; $display("FAIL fast_div got res=%h lat=%0d exp res=0000000e lat=33", res, lat);
        end
        test_random(1'b1, 16);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random(1'b0, 40);
        test_backpressure();
        test_flush_reset();
        test_fast_mul();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
